imem_loader_arb: RTL and testbench

Parametrised program loader and memory-port arbiter for the MIPS computer. It accepts streamed instruction words and addressed data words, and writes them into the instruction and data RAMs. It holds the core in reset while loading, then hands both RAM ports to the core. A reload request re-enters loading at run time.

---
 rtl/imem_loader_arb_if.sv | 60 ++++++
 rtl/imem_loader_arb.sv | 144 ++++++++++++++
 tb/tb_imem_loader_arb.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_arb_if.sv
// Bundle of loader stream, core access and RAM port signals for imem_loader_arb.
// The slave modport is the arbiter's view; the master modport is the loader/core side.
interface imem_loader_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int INS_AW     = 5,
    parameter int DATA_AW    = 5
);
    logic [DATA_WIDTH-1:0] ins_i;
    logic                  ins_vld;
    logic                  ins_last;
    logic                  ins_rdy;

    logic [DATA_WIDTH-1:0] data_i;
    logic [31:0]           data_addr_i;
    logic                  data_vld;
    logic                  data_rdy;

    logic                  reload;

    logic [31:0]           core_ins_addr;
    logic [31:0]           core_data_addr;
    logic [DATA_WIDTH-1:0] core_data_wr;
    logic                  core_data_wr_en;

    logic                  ins_mem_wr_en;
    logic [DATA_WIDTH-1:0] ins_mem_din;
    logic [INS_AW-1:0]     ins_mem_addr;
    logic                  data_mem_wr_en;
    logic [DATA_WIDTH-1:0] data_mem_din;
    logic [DATA_AW-1:0]    data_mem_addr;

    logic                  core_rst_n;
    logic                  programing;
    logic [INS_AW:0]       ins_count;
    logic                  load_err;

    modport slave (
        input  ins_i, ins_vld, ins_last,
        output ins_rdy,
        input  data_i, data_addr_i, data_vld,
        output data_rdy,
        input  reload,
        input  core_ins_addr, core_data_addr, core_data_wr, core_data_wr_en,
        output ins_mem_wr_en, ins_mem_din, ins_mem_addr,
        output data_mem_wr_en, data_mem_din, data_mem_addr,
        output core_rst_n, programing, ins_count, load_err
    );

    modport master (
        output ins_i, ins_vld, ins_last,
        input  ins_rdy,
        output data_i, data_addr_i, data_vld,
        input  data_rdy,
        output reload,
        output core_ins_addr, core_data_addr, core_data_wr, core_data_wr_en,
        input  ins_mem_wr_en, ins_mem_din, ins_mem_addr,
        input  data_mem_wr_en, data_mem_din, data_mem_addr,
        input  core_rst_n, programing, ins_count, load_err
    );
endinterface

// File: rtl/imem_loader_arb.sv
// Program loader and RAM port arbiter: streams code/data into the RAMs while the core is held in reset.
// Optional macro IMEM_ZERO_FILL_EN adds a FILL state that zeroes the unloaded instruction words.
module imem_loader_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int INS_AW     = 5,
    parameter int DATA_AW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_loader_arb_if.slave  bus
);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [INS_AW:0] DEPTH = {1'b1, {INS_AW{1'b0}}};

    logic [1:0]      state_q,   state_d;
    logic [INS_AW:0] ptr_q,     ptr_d;
    logic [INS_AW:0] cnt_q,     cnt_d;
    logic            err_q,     err_d;
    logic            coreRst_q, coreRst_d;

    logic insAcc;
    logic insFull;
    logic dataAcc;
    logic dataInRange;
    logic loadPhase;

    assign loadPhase   = (state_q == ST_LOAD);
    assign insAcc      = bus.ins_vld  & loadPhase;
    assign dataAcc     = bus.data_vld & loadPhase;
    assign insFull     = (cnt_q == DEPTH);
    assign dataInRange = (bus.data_addr_i[31:DATA_AW+2] == '0);

    // Next-state, pointer, count and sticky error update
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_LOAD: begin
                if (insAcc) begin
                    if (insFull) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (bus.ins_last) begin
`ifdef IMEM_ZERO_FILL_EN
                        state_d = (ptr_d == DEPTH) ? ST_RUN : ST_FILL;
`else
                        state_d = ST_RUN;
`endif
                    end
                end
                if (dataAcc && !dataInRange) begin
                    err_d = 1'b1;
                end
            end
`ifdef IMEM_ZERO_FILL_EN
            ST_FILL: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == DEPTH - 1'b1) begin
                    state_d = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                if (bus.reload) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Core leaves reset one cycle after RUN is entered, but drops on the same edge as reload
    assign coreRst_d = (state_q == ST_RUN) && !bus.reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            ptr_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            coreRst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            coreRst_q <= coreRst_d;
        end
    end

    // RAM port mux: loader owns the ports until RUN, then the core drives them directly
    always_comb begin
        bus.ins_mem_wr_en  = 1'b0;
        bus.ins_mem_din    = bus.ins_i;
        bus.ins_mem_addr   = ptr_q[INS_AW-1:0];
        bus.data_mem_wr_en = 1'b0;
        bus.data_mem_din   = bus.data_i;
        bus.data_mem_addr  = bus.data_addr_i[DATA_AW+1:2];
        case (state_q)
            ST_LOAD: begin
                bus.ins_mem_wr_en  = insAcc & ~insFull;
                bus.data_mem_wr_en = dataAcc & dataInRange;
            end
`ifdef IMEM_ZERO_FILL_EN
            ST_FILL: begin
                bus.ins_mem_wr_en = 1'b1;
                bus.ins_mem_din   = '0;
            end
`endif
            ST_RUN: begin
                bus.ins_mem_addr   = bus.core_ins_addr[INS_AW+1:2];
                bus.data_mem_addr  = bus.core_data_addr[DATA_AW+1:2];
                bus.data_mem_din   = bus.core_data_wr;
                bus.data_mem_wr_en = bus.core_data_wr_en;
            end
            default: begin
                bus.ins_mem_wr_en  = 1'b0;
                bus.data_mem_wr_en = 1'b0;
            end
        endcase
    end

    assign bus.ins_rdy    = loadPhase;
    assign bus.data_rdy   = loadPhase;
    assign bus.programing = (state_q != ST_RUN);
    assign bus.core_rst_n = coreRst_q;
    assign bus.ins_count  = cnt_q;
    assign bus.load_err   = err_q;

endmodule

// File: tb/tb_imem_loader_arb.sv
// Scoreboard bench for imem_loader_arb: expected RAM writes are queued at stimulus time
// and matched against every write strobe the DUT produces.
module tb_imem_loader_arb;

    localparam int DATA_WIDTH = 32;
    localparam int INS_AW     = 5;
    localparam int DATA_AW    = 5;
    localparam int DEPTH      = 1 << INS_AW;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wrExp_t;

    logic clk;
    logic rst_n;

    int assertCount = 0;
    int failCount   = 0;

    int   modelCnt;
    logic modelErr;

    wrExp_t insQ[$];
    wrExp_t dataQ[$];

    imem_loader_arb_if #(.DATA_WIDTH(DATA_WIDTH), .INS_AW(INS_AW), .DATA_AW(DATA_AW)) bus ();

    imem_loader_arb #(.DATA_WIDTH(DATA_WIDTH), .INS_AW(INS_AW), .DATA_AW(DATA_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write monitor: every RAM strobe must match the oldest queued expectation
    always @(negedge clk) begin
        wrExp_t e;
        if (bus.ins_mem_wr_en === 1'b1) begin
            if (insQ.size() == 0) begin
                checkOutput("insUnexpectedWrite", 64'(bus.ins_mem_addr), 64'hFFFF);
            end else begin
                e = insQ.pop_front();
                checkOutput("insAddr", 64'(bus.ins_mem_addr), 64'(e.addr));
                checkOutput("insData", 64'(bus.ins_mem_din), 64'(e.data));
            end
        end
        if (bus.data_mem_wr_en === 1'b1) begin
            if (dataQ.size() == 0) begin
                checkOutput("dataUnexpectedWrite", 64'(bus.data_mem_addr), 64'hFFFF);
            end else begin
                e = dataQ.pop_front();
                checkOutput("dataAddr", 64'(bus.data_mem_addr), 64'(e.addr));
                checkOutput("dataData", 64'(bus.data_mem_din), 64'(e.data));
            end
        end
    end

    // One LOAD cycle with optional ins and data beats; expected writes come from the bench model
    task automatic applyStimulus(input logic doIns, input logic [31:0] insWord, input logic last,
                                 input logic doData, input logic [31:0] addr, input logic [31:0] val);
        wrExp_t e;
        logic [31:0] upper;
        bus.ins_vld     = doIns;
        bus.ins_i       = insWord;
        bus.ins_last    = last;
        bus.data_vld    = doData;
        bus.data_addr_i = addr;
        bus.data_i      = val;
        if (doIns) begin
            if (modelCnt < DEPTH) begin
                e.addr = modelCnt;
                e.data = insWord;
                insQ.push_back(e);
                modelCnt++;
            end else begin
                modelErr = 1'b1;
            end
        end
        if (doData) begin
            upper = addr >> (DATA_AW + 2);
            if (upper == 0) begin
                e.addr = int'((addr >> 2) & ((1 << DATA_AW) - 1));
                e.data = val;
                dataQ.push_back(e);
            end else begin
                modelErr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.ins_vld  = 1'b0;
        bus.ins_last = 1'b0;
        bus.data_vld = 1'b0;
        checkOutput("insCount", 64'(bus.ins_count), 64'(modelCnt));
        checkOutput("loadErr", 64'(bus.load_err), 64'(modelErr));
    endtask

    // Called #1 after the edge that accepted ins_last
    task automatic finishLoad(input int nWritten);
`ifdef IMEM_ZERO_FILL_EN
        int cycles = 0;
        wrExp_t e;
        for (int a = nWritten; a < DEPTH; a++) begin
            e.addr = a;
            e.data = '0;
            insQ.push_back(e);
        end
        while (bus.programing === 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("fillCycles", 64'(cycles), 64'(DEPTH - nWritten));
`endif
        checkOutput("programingLow", 64'(bus.programing), 64'd0);
        checkOutput("coreRstStillLow", 64'(bus.core_rst_n), 64'd0);
        checkOutput("insRdyRun", 64'(bus.ins_rdy), 64'd0);
        checkOutput("dataRdyRun", 64'(bus.data_rdy), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("coreRstHigh", 64'(bus.core_rst_n), 64'd1);
    endtask

    task automatic pulseReload();
        bus.reload = 1'b1;
        @(posedge clk);
        #1;
        bus.reload = 1'b0;
        modelCnt = 0;
        modelErr = 1'b0;
    endtask

    initial begin
        wrExp_t e;
        rst_n               = 1'b0;
        bus.ins_i           = '0;
        bus.ins_vld         = 1'b0;
        bus.ins_last        = 1'b0;
        bus.data_i          = '0;
        bus.data_addr_i     = '0;
        bus.data_vld        = 1'b0;
        bus.reload          = 1'b0;
        bus.core_ins_addr   = '0;
        bus.core_data_addr  = '0;
        bus.core_data_wr    = '0;
        bus.core_data_wr_en = 1'b0;
        modelCnt = 0;
        modelErr = 1'b0;

        #12;
        checkOutput("rstInsCount", 64'(bus.ins_count), 64'd0);
        checkOutput("rstLoadErr", 64'(bus.load_err), 64'd0);
        checkOutput("rstCoreRst", 64'(bus.core_rst_n), 64'd0);
        checkOutput("rstPrograming", 64'(bus.programing), 64'd1);
        checkOutput("rstInsRdy", 64'(bus.ins_rdy), 64'd1);
        checkOutput("rstDataRdy", 64'(bus.data_rdy), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First load: three words, the last one alongside a data beat at 0x0C
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 32'h33, 1'b1, 1'b1, 32'h0C, 32'hDEAD);
        finishLoad(3);

        // RUN: core owns the ports, loader beats are refused
        bus.core_ins_addr  = 32'h14;
        bus.core_data_addr = 32'h10;
        bus.core_data_wr   = 32'h5;
        bus.ins_vld        = 1'b1;
        bus.ins_i          = 32'hBAD;
        #1;
        checkOutput("runInsAddr", 64'(bus.ins_mem_addr), 64'd5);
        checkOutput("runDataAddr", 64'(bus.data_mem_addr), 64'd4);
        checkOutput("runInsWrEn", 64'(bus.ins_mem_wr_en), 64'd0);
        checkOutput("runDataWrEnIdle", 64'(bus.data_mem_wr_en), 64'd0);
        e.addr = 4;
        e.data = 32'h5;
        dataQ.push_back(e);
        bus.core_data_wr_en = 1'b1;
        @(posedge clk);
        #1;
        bus.core_data_wr_en = 1'b0;
        bus.ins_vld         = 1'b0;
        checkOutput("runInsCountHeld", 64'(bus.ins_count), 64'd3);

        pulseReload();
        checkOutput("reloadCoreRst", 64'(bus.core_rst_n), 64'd0);
        checkOutput("reloadPrograming", 64'(bus.programing), 64'd1);
        checkOutput("reloadInsCount", 64'(bus.ins_count), 64'd0);
        checkOutput("reloadInsRdy", 64'(bus.ins_rdy), 64'd1);

        // Second load: byte-offset data, out-of-range data, ignored reload, then overflow
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0E, 32'hBEEF);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 32'h1234);
        bus.reload = 1'b1;
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.reload = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), (i == DEPTH), 1'b0, 32'h0, 32'h0);
        end
        checkOutput("overflowCount", 64'(bus.ins_count), 64'(DEPTH));
        finishLoad(DEPTH);
        checkOutput("errStickyRun", 64'(bus.load_err), 64'd1);

        // Reset in the middle of a load returns everything to reset values
        pulseReload();
        applyStimulus(1'b1, 32'h77, 1'b0, 1'b1, 32'h100, 32'h0);
        applyStimulus(1'b1, 32'h78, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #2;
        modelCnt = 0;
        modelErr = 1'b0;
        checkOutput("midRstInsCount", 64'(bus.ins_count), 64'd0);
        checkOutput("midRstLoadErr", 64'(bus.load_err), 64'd0);
        checkOutput("midRstPrograming", 64'(bus.programing), 64'd1);
        checkOutput("midRstCoreRst", 64'(bus.core_rst_n), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Short load: pointer restarts at zero
        applyStimulus(1'b1, 32'hAA, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 32'hBB, 1'b1, 1'b0, 32'h0, 32'h0);
        finishLoad(2);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("insQueueDrained", 64'(insQ.size()), 64'd0);
        checkOutput("dataQueueDrained", 64'(dataQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
